cache_mem_arbiter: RTL and testbench

CACHE_MEM_ARBITER -- requirements
Module: cache_mem_arbiter

---
 rtl/cache_mem_arbiter_if.sv | 36 +++
 rtl/cache_mem_arbiter.sv | 96 +++++++++
 tb/tb_cache_mem_arbiter.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/cache_mem_arbiter_if.sv
// Bundle of I-cache, D-cache and memory signals around the cache/memory arbiter.
// The master modport is the arbiter's view; slave is the surrounding caches and memory.
interface cache_mem_arbiter_if #(
    parameter int A_WIDTH = 32
);
    logic [A_WIDTH-1:0] i_a;
    logic               i_strobe;
    logic [31:0]        i_dout;
    logic               i_ready;

    logic [A_WIDTH-1:0] d_a;
    logic               d_strobe;
    logic               d_rw;
    logic [31:0]        d_wdata;
    logic [31:0]        d_dout;
    logic               d_ready;

    logic [A_WIDTH-1:0] m_a;
    logic               m_strobe;
    logic               m_rw;
    logic [31:0]        m_din;
    logic [31:0]        m_dout;
    logic               m_ready;

    logic               busy;

    modport master (
        input  i_a, i_strobe, d_a, d_strobe, d_rw, d_wdata, m_dout, m_ready,
        output i_dout, i_ready, d_dout, d_ready, m_a, m_strobe, m_rw, m_din, busy
    );

    modport slave (
        output i_a, i_strobe, d_a, d_strobe, d_rw, d_wdata, m_dout, m_ready,
        input  i_dout, i_ready, d_dout, d_ready, m_a, m_strobe, m_rw, m_din, busy
    );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Arbitrates a single memory port between I-cache and D-cache requests.
// D wins ties until it has taken MAX_D_STREAK grants in a row while I waited.
module cache_mem_arbiter #(
    parameter int A_WIDTH      = 32,
    parameter int MAX_D_STREAK = 4
) (
    input logic                clk,
    input logic                clrn,
    cache_mem_arbiter_if.master bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_BUSY = 2'd2
    } state_t;

    localparam logic [3:0] MAX_STREAK = 4'(MAX_D_STREAK);

    state_t             r_state;
    state_t             w_next;
    logic               w_grant_i;
    logic               w_grant_d;

    logic [A_WIDTH-1:0] r_addr;
    logic               r_rw;
    logic [31:0]        r_wdata;
    logic [3:0]         r_streak;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Grants only come from IDLE, which enforces the idle cycle between transactions.
    always_comb begin
        w_next    = r_state;
        w_grant_i = 1'b0;
        w_grant_d = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.d_strobe && (!bus.i_strobe || (r_streak != MAX_STREAK))) begin
                    w_grant_d = 1'b1;
                    w_next    = D_BUSY;
                end else if (bus.i_strobe) begin
                    w_grant_i = 1'b1;
                    w_next    = I_BUSY;
                end
            end
            I_BUSY, D_BUSY: begin
                if (bus.m_ready) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_addr   <= '0;
            r_rw     <= 1'b0;
            r_wdata  <= '0;
            r_streak <= '0;
        end else if (w_grant_d) begin
            r_addr  <= bus.d_a;
            r_rw    <= bus.d_rw;
            r_wdata <= bus.d_wdata;
            if (!bus.i_strobe) begin
                r_streak <= '0;
            end else if (r_streak != MAX_STREAK) begin
                r_streak <= r_streak + 4'd1;
            end
        end else if (w_grant_i) begin
            r_addr   <= bus.i_a;
            r_rw     <= 1'b0;
            r_streak <= '0;
        end
    end

    always_comb begin
        bus.m_a      = r_addr;
        bus.m_din    = r_wdata;
        bus.m_strobe = (r_state != IDLE);
        bus.m_rw     = (r_state == D_BUSY) && r_rw;
        bus.i_ready  = (r_state == I_BUSY) && bus.m_ready;
        bus.d_ready  = (r_state == D_BUSY) && bus.m_ready;
        bus.i_dout   = bus.m_dout;
        bus.d_dout   = bus.m_dout;
        bus.busy     = (r_state != IDLE);
    end
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench: directed vector table, multi-cycle corner sequences,
// and randomized traffic compared against a transaction-level reference model.
module tb_cache_mem_arbiter;
    localparam int AW   = 32;
    localparam int MAXD = 4;

    logic clk = 1'b0;
    logic clrn;
    always #5 clk = ~clk;

    cache_mem_arbiter_if #(.A_WIDTH(AW)) bus();

    cache_mem_arbiter #(.A_WIDTH(AW), .MAX_D_STREAK(MAXD)) dut (
        .clk (clk),
        .clrn(clrn),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        is, ds, rw, mr;
        logic [31:0] ia, da, wd, md;
        logic        e_ms, e_rw, e_ir, e_dr;
        logic [31:0] e_ma, e_mdin;
    } vec_t;

    vec_t tbl[10];

    function automatic vec_t mk(logic is, logic ds, logic rw, logic mr,
                                logic [31:0] ia, logic [31:0] da, logic [31:0] wd, logic [31:0] md,
                                logic ems, logic erw, logic eir, logic edr,
                                logic [31:0] ema, logic [31:0] emdin);
        vec_t v;
        v.is = is; v.ds = ds; v.rw = rw; v.mr = mr;
        v.ia = ia; v.da = da; v.wd = wd; v.md = md;
        v.e_ms = ems; v.e_rw = erw; v.e_ir = eir; v.e_dr = edr;
        v.e_ma = ema; v.e_mdin = emdin;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic is, input logic ds, input logic rw, input logic mr,
                         input logic [31:0] ia, input logic [31:0] da,
                         input logic [31:0] wd, input logic [31:0] md);
        bus.i_strobe = is; bus.d_strobe = ds; bus.d_rw = rw; bus.m_ready = mr;
        bus.i_a = ia; bus.d_a = da; bus.d_wdata = wd; bus.m_dout = md;
    endtask

    task automatic do_reset();
        clrn = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0);
        tick();
        tick();
        chk("rst_m_strobe", {63'd0, bus.m_strobe}, 64'd0);
        chk("rst_busy",     {63'd0, bus.busy},     64'd0);
        chk("rst_ready",    {62'd0, bus.i_ready, bus.d_ready}, 64'd0);
        chk("rst_m_rw",     {63'd0, bus.m_rw},     64'd0);
        chk("rst_m_a",      {32'd0, bus.m_a},      64'd0);
        chk("rst_m_din",    {32'd0, bus.m_din},    64'd0);
        bus.m_ready = 1'b0;
        #1;
        clrn = 1'b1;
        tick();
    endtask

    // Reference model state: who owns memory, what was captured, D-streak length.
    int          owner;
    int          streak;
    logic [31:0] lat_a, lat_wd;
    logic        lat_rw;

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] ia_k, da_k;
        bit          found;

        tbl[0] = mk(0,0,0,1, 32'h0,        32'h0,        32'h0,        32'h5555_AAAA, 0,0,0,0, 32'h0,        32'h0);
        tbl[1] = mk(1,0,0,0, 32'h1FC0_0000,32'h0,        32'h0,        32'h0,         0,0,0,0, 32'h0,        32'h0);
        tbl[2] = mk(1,0,0,0, 32'h1FC0_0000,32'h0,        32'h0,        32'h0,         1,0,0,0, 32'h1FC0_0000,32'h0);
        tbl[3] = mk(1,0,0,0, 32'h1FC0_0000,32'h0,        32'h0,        32'h0,         1,0,0,0, 32'h1FC0_0000,32'h0);
        tbl[4] = mk(1,0,0,1, 32'h1FC0_0000,32'h0,        32'h0,        32'h2408_0001, 1,0,1,0, 32'h1FC0_0000,32'h0);
        tbl[5] = mk(0,0,0,0, 32'h0,        32'h0,        32'h0,        32'h0,         0,0,0,0, 32'h1FC0_0000,32'h0);
        tbl[6] = mk(0,1,1,0, 32'h0,        32'h8000_0010,32'hDEAD_BEEF,32'h0,         0,0,0,0, 32'h1FC0_0000,32'h0);
        tbl[7] = mk(0,0,0,0, 32'h0,        32'h0,        32'h0,        32'h0,         1,1,0,0, 32'h8000_0010,32'hDEAD_BEEF);
        tbl[8] = mk(0,0,0,1, 32'h0,        32'h0,        32'h0,        32'h1234_5678, 1,1,0,1, 32'h8000_0010,32'hDEAD_BEEF);
        tbl[9] = mk(0,0,0,0, 32'h0,        32'h0,        32'h0,        32'h0,         0,0,0,0, 32'h8000_0010,32'hDEAD_BEEF);

        do_reset();
        for (int r = 0; r < 10; r++) begin
            drive(tbl[r].is, tbl[r].ds, tbl[r].rw, tbl[r].mr, tbl[r].ia, tbl[r].da, tbl[r].wd, tbl[r].md);
            #2;
            chk($sformatf("tbl%0d_m_strobe", r), {63'd0, bus.m_strobe}, {63'd0, tbl[r].e_ms});
            chk($sformatf("tbl%0d_m_rw", r),     {63'd0, bus.m_rw},     {63'd0, tbl[r].e_rw});
            chk($sformatf("tbl%0d_i_ready", r),  {63'd0, bus.i_ready},  {63'd0, tbl[r].e_ir});
            chk($sformatf("tbl%0d_d_ready", r),  {63'd0, bus.d_ready},  {63'd0, tbl[r].e_dr});
            chk($sformatf("tbl%0d_busy", r),     {63'd0, bus.busy},     {63'd0, tbl[r].e_ms});
            chk($sformatf("tbl%0d_m_a", r),      {32'd0, bus.m_a},      {32'd0, tbl[r].e_ma});
            chk($sformatf("tbl%0d_m_din", r),    {32'd0, bus.m_din},    {32'd0, tbl[r].e_mdin});
            chk($sformatf("tbl%0d_i_dout", r),   {32'd0, bus.i_dout},   {32'd0, tbl[r].md});
            chk($sformatf("tbl%0d_d_dout", r),   {32'd0, bus.d_dout},   {32'd0, tbl[r].md});
            tick();
        end

        // Both requesters held: D,D,D,D,I repeating.
        do_reset();
        ia_k = 32'h1000_0000;
        da_k = 32'h2000_0000;
        drive(1'b1, 1'b1, 1'b0, 1'b0, ia_k, da_k, 32'h0, 32'h0);
        for (int g = 0; g < 10; g++) begin
            found = 1'b0;
            for (int k = 0; k < 8; k++) begin
                if (bus.m_strobe) begin
                    found = 1'b1;
                    break;
                end
                tick();
            end
            chk($sformatf("streak_grant%0d_seen", g), {63'd0, found}, 64'd1);
            chk($sformatf("streak_grant%0d_addr", g), {32'd0, bus.m_a},
                {32'd0, ((g % 5) == 4) ? ia_k : da_k});
            tick();
            bus.m_ready = 1'b1;
            #1;
            chk($sformatf("streak_grant%0d_ready", g), {62'd0, bus.i_ready, bus.d_ready},
                ((g % 5) == 4) ? 64'd2 : 64'd1);
            tick();
            bus.m_ready = 1'b0;
        end

        // Simultaneous first request: D wins, i_a changes while I waits.
        do_reset();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'hAAAA_0000, 32'hBBBB_0000, 32'h0, 32'h0);
        tick();
        chk("tie_m_strobe", {63'd0, bus.m_strobe}, 64'd1);
        chk("tie_m_a_d",    {32'd0, bus.m_a}, {32'd0, 32'hBBBB_0000});
        bus.i_a = 32'hCCCC_0000;
        tick();
        chk("tie_m_a_hold", {32'd0, bus.m_a}, {32'd0, 32'hBBBB_0000});
        bus.m_ready = 1'b1;
        #1;
        chk("tie_ready", {62'd0, bus.i_ready, bus.d_ready}, 64'd1);
        tick();
        bus.m_ready  = 1'b0;
        bus.d_strobe = 1'b0;
        chk("tie_idle_gap", {63'd0, bus.m_strobe}, 64'd0);
        tick();
        chk("tie_i_grant_a", {32'd0, bus.m_a}, {32'd0, 32'hCCCC_0000});
        chk("tie_i_grant_rw", {63'd0, bus.m_rw}, 64'd0);
        bus.m_ready = 1'b1;
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);

        // Reset in the middle of a D write abandons it.
        do_reset();
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h8000_0010, 32'hDEAD_BEEF, 32'h0);
        tick();
        chk("abort_busy_before", {63'd0, bus.busy}, 64'd1);
        chk("abort_m_rw_before", {63'd0, bus.m_rw}, 64'd1);
        #1;
        clrn = 1'b0;
        #1;
        chk("abort_m_strobe", {63'd0, bus.m_strobe}, 64'd0);
        chk("abort_busy",     {63'd0, bus.busy},     64'd0);
        chk("abort_m_a",      {32'd0, bus.m_a},      64'd0);
        chk("abort_m_din",    {32'd0, bus.m_din},    64'd0);
        bus.d_strobe = 1'b0;
        tick();
        clrn = 1'b1;
        tick();
        bus.m_ready = 1'b1;
        #1;
        chk("abort_no_ready", {62'd0, bus.i_ready, bus.d_ready}, 64'd0);
        tick();
        bus.m_ready = 1'b0;
        chk("abort_idle", {63'd0, bus.m_strobe}, 64'd0);

        // Randomized traffic against the transaction-level model.
        do_reset();
        owner = 0; streak = 0; lat_a = '0; lat_wd = '0; lat_rw = 1'b0;
        for (int c = 0; c < 600; c++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 9) < 3), $urandom, $urandom, $urandom, $urandom);
            #2;
            chk("rnd_m_strobe", {63'd0, bus.m_strobe}, {63'd0, owner != 0});
            chk("rnd_busy",     {63'd0, bus.busy},     {63'd0, owner != 0});
            chk("rnd_m_rw",     {63'd0, bus.m_rw},     {63'd0, (owner == 2) && lat_rw});
            chk("rnd_m_a",      {32'd0, bus.m_a},      {32'd0, lat_a});
            chk("rnd_m_din",    {32'd0, bus.m_din},    {32'd0, lat_wd});
            chk("rnd_i_ready",  {63'd0, bus.i_ready},  {63'd0, (owner == 1) && bus.m_ready});
            chk("rnd_d_ready",  {63'd0, bus.d_ready},  {63'd0, (owner == 2) && bus.m_ready});
            chk("rnd_dout",     {bus.i_dout, bus.d_dout}, {bus.m_dout, bus.m_dout});
            if (owner != 0) begin
                if (bus.m_ready) owner = 0;
            end else if (bus.i_strobe && bus.d_strobe && streak == MAXD) begin
                owner = 1; lat_a = bus.i_a; streak = 0;
            end else if (bus.d_strobe) begin
                owner = 2; lat_a = bus.d_a; lat_rw = bus.d_rw; lat_wd = bus.d_wdata;
                streak = bus.i_strobe ? ((streak < MAXD) ? streak + 1 : MAXD) : 0;
            end else if (bus.i_strobe) begin
                owner = 1; lat_a = bus.i_a; streak = 0;
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
